// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution output path.
package conv_pkg;
    localparam int ACC_W   = 24;
    localparam int ADDR_W  = 13;
    localparam int OUT_W   = 8;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/requant_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop frees a slot that same cycle.
module requant_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end
endmodule

// File: rtl/output_requant_drain.sv
// Drains the accumulation buffer through bias add, arithmetic shift and int8 saturation into a FIFO.
// Build option: define OUTPUT_RELU_EN to clamp negative biased sums to zero before the shift.
module output_requant_drain #(
    parameter int ADDR_W     = conv_pkg::ADDR_W,
    parameter int ACC_W      = conv_pkg::ACC_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_W:0]                  num_pixels,
    input  logic signed [ACC_W-1:0]          bias,
    input  logic [4:0]                       shift,
    output logic                             rd_en,
    output logic [ADDR_W-1:0]                rd_addr,
    input  logic signed [ACC_W-1:0]          rd_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [conv_pkg::OUT_W-1:0] out_data,
    output logic [ADDR_W-1:0]                out_addr,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);
    import conv_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = ACC_W + 1;
    localparam int ENT_W = OUT_W + ADDR_W + 1;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(SAT_MAX);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(SAT_MIN);

    function automatic logic signed [SUM_W-1:0] f_sext(input logic signed [ACC_W-1:0] v);
        return {v[ACC_W-1], v};
    endfunction

`ifdef OUTPUT_RELU_EN
    function automatic logic signed [SUM_W-1:0] f_relu(input logic signed [SUM_W-1:0] v);
        return (v < 0) ? '0 : v;
    endfunction
`endif

    function automatic logic signed [OUT_W-1:0] f_requant(input logic signed [SUM_W-1:0] v,
                                                         input logic [4:0]              sh);
        logic signed [SUM_W-1:0] s;
        s = v >>> sh;
        if (s > SUM_MAX)      return OUT_W'(SAT_MAX);
        else if (s < SUM_MIN) return OUT_W'(SAT_MIN);
        else                  return s[OUT_W-1:0];
    endfunction

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [ADDR_W:0]         r_num;
    logic [ADDR_W:0]         r_rd_cnt;
    logic [CNT_W-1:0]        r_inflight;
    logic signed [ACC_W-1:0] r_bias;
    logic [4:0]              r_shift;
    logic                    w_accept;
    logic                    w_credit;
    logic                    w_rd_last;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [CNT_W-1:0]        w_fifo_cnt;
    logic [ENT_W-1:0]        w_push_data;
    logic [ENT_W-1:0]        w_head;

    logic                    r_vld_p0, r_vld_p1, r_vld_p2;
    logic [ADDR_W-1:0]       r_addr_p0, r_addr_p1, r_addr_p2;
    logic                    r_last_p0, r_last_p1, r_last_p2;
    logic signed [ACC_W-1:0] r_acc_p1;
    logic signed [SUM_W-1:0] r_sum_p2;
    logic signed [SUM_W-1:0] w_sum_p1;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_rd_last = (r_rd_cnt == r_num - (ADDR_W+1)'(1));
    // Reads in flight plus FIFO occupancy bounds the FIFO, so a stalled sink can never overflow it.
    assign w_credit  = !w_full &&
                       (({1'b0, r_inflight} + {1'b0, w_fifo_cnt}) < (CNT_W+1)'(FIFO_DEPTH));
    assign rd_addr   = r_rd_cnt[ADDR_W-1:0];
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

    always_comb begin
        w_state_nx = r_state;
        rd_en      = 1'b0;
        case (r_state)
            IDLE:  if (start) w_state_nx = (num_pixels == '0) ? DONE : RUN;
            RUN: begin
                rd_en = w_credit;
                if (w_credit && w_rd_last) w_state_nx = DRAIN;
            end
            DRAIN: if (out_valid && out_ready && out_last) w_state_nx = DONE;
            DONE:  w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_num      <= '0;
            r_rd_cnt   <= '0;
            r_inflight <= '0;
            r_vld_p0   <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_vld_p0 <= rd_en;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            if (w_accept) begin
                r_num    <= num_pixels;
                r_rd_cnt <= '0;
            end else if (rd_en) begin
                r_rd_cnt <= r_rd_cnt + (ADDR_W+1)'(1);
            end
            case ({rd_en, w_push})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign w_sum_p1 = f_sext(r_acc_p1) + f_sext(r_bias);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_bias  <= bias;
            r_shift <= shift;
        end
        // p0: address of the read whose data arrives next cycle
        r_addr_p0 <= rd_addr;
        r_last_p0 <= w_rd_last;
        // p1: capture buffer data
        r_acc_p1  <= rd_data;
        r_addr_p1 <= r_addr_p0;
        r_last_p1 <= r_last_p0;
        // p2: widened bias add
`ifdef OUTPUT_RELU_EN
        r_sum_p2  <= f_relu(w_sum_p1);
`else
        r_sum_p2  <= w_sum_p1;
`endif
        r_addr_p2 <= r_addr_p1;
        r_last_p2 <= r_last_p1;
    end

    // p3: shift, saturate and push into the FIFO
    assign w_push      = r_vld_p2;
    assign w_push_data = {f_requant(r_sum_p2, r_shift), r_addr_p2, r_last_p2};
    assign w_pop       = out_valid && out_ready;

    requant_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_fifo_cnt)
    );

    assign out_valid = !w_empty;
    assign out_data  = w_head[ENT_W-1 -: OUT_W];
    assign out_addr  = w_head[ADDR_W:1];
    assign out_last  = !w_empty && w_head[0];
endmodule
